// File: rtl/serial_bit_source_pkg.sv
// Shared definitions for the serial bit source: FSM state encoding and a
// width helper for counters that must be at least one bit wide.
package serial_bit_source_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Bits needed to count 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_bit_source_if.sv
// Load handshake between a word producer and the serial bit source.
// valid/ready: a word moves on a rising edge where load_valid and load_ready
// are both 1; the producer holds data_in stable while load_valid is 1 and
// ready is 0, and load_ready never depends combinationally on load_valid.
interface serial_bit_source_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;

    modport master (output data_in, output load_valid, input load_ready);
    modport slave  (input data_in, input load_valid, output load_ready);
endinterface

// File: rtl/serial_bit_source_bit_tick_gen.sv
// Bit-period prescaler: counts 0..DIV-1 while running and flags the last
// cycle of each bit period. A restart pulls the count back to zero.
module serial_bit_source_bit_tick_gen
    import serial_bit_source_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic CLOCK,
    input  logic reset,
    input  logic restart,
    input  logic run,
    output logic tick
);
    localparam int            CW   = clog2_min1(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt_q, div_cnt_d;

    assign tick = run & (div_cnt_q == LAST);

    // Next count: restart wins, otherwise wrap to zero at the terminal value.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (restart) begin
            div_cnt_d = '0;
        end else if (run) begin
            div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + 1'b1;
        end
    end

    // Counter register with asynchronous clear.
    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end
endmodule

// File: rtl/serial_bit_source.sv
// Serial bit source: takes parallel words over a valid/ready handshake and
// shifts them out on X one bit per DIV clocks. A one-word hold buffer lets a
// second word queue up so consecutive words stream without an idle gap.
module serial_bit_source
    import serial_bit_source_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter int   DIV       = 1,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b1
) (
    input  logic               CLOCK,
    input  logic               reset,
    serial_bit_source_if.slave ld,
    output logic               X,
    output logic               bit_valid,
    output logic               busy,
    output logic               done,
    output state_e             dbg_state
);
    localparam int             BCW      = clog2_min1(WIDTH);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic             x_q, x_d;
    logic             bv_q, bv_d;
    logic             done_q, done_d;
    logic             accept, tick, restart, word_end, shifting;

    // The shift register holds only the bits not yet placed on X.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] drop_first(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign ld.load_ready = ~hold_full_q;
    assign accept        = ld.load_valid & ~hold_full_q;
    assign shifting      = (state_q == ST_SHIFT);
    assign word_end      = shifting & tick & (bit_cnt_q == LAST_BIT);

    serial_bit_source_bit_tick_gen #(
        .DIV(DIV)
    ) u_tick (
        .CLOCK  (CLOCK),
        .reset  (reset),
        .restart(restart),
        .run    (shifting),
        .tick   (tick)
    );

    // Next state, shift/hold datapath and registered output values.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_cnt_d   = bit_cnt_q;
        x_d         = x_q;
        bv_d        = 1'b0;
        done_d      = 1'b0;
        restart     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shreg_d   = drop_first(ld.data_in);
                    x_d       = first_bit(ld.data_in);
                    bv_d      = 1'b1;
                    bit_cnt_d = '0;
                    restart   = 1'b1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (word_end) begin
                    bit_cnt_d = '0;
                    if (hold_full_q) begin
                        shreg_d     = drop_first(hold_q);
                        x_d         = first_bit(hold_q);
                        bv_d        = 1'b1;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        shreg_d = drop_first(ld.data_in);
                        x_d     = first_bit(ld.data_in);
                        bv_d    = 1'b1;
                    end else begin
                        x_d     = IDLE_BIT;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (tick) begin
                        x_d       = first_bit(shreg_q);
                        shreg_d   = drop_first(shreg_q);
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        bv_d      = 1'b1;
                    end
                    if (accept) begin
                        hold_d      = ld.data_in;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any word in flight.
    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            x_q         <= IDLE_BIT;
            bv_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
            x_q         <= x_d;
            bv_q        <= bv_d;
            done_q      <= done_d;
        end
    end

    assign X         = x_q;
    assign bit_valid = bv_q;
    assign done      = done_q;
    assign busy      = shifting;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_serial_bit_source.sv
// Bench for serial_bit_source: two instances (DIV=1 MSB first, DIV=3 LSB
// first) checked every cycle against a timeline model, a word scoreboard fed
// by a deserializer, and directed cases with hand-computed bit patterns.
module tb_serial_bit_source;
    import serial_bit_source_pkg::*;

    localparam int W    = 8;
    localparam int DIV0 = 1;
    localparam int DIV1 = 3;
    localparam bit MSB0 = 1'b1;
    localparam bit MSB1 = 1'b0;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_bit_source_if #(.WIDTH(W)) if0 ();
    serial_bit_source_if #(.WIDTH(W)) if1 ();

    logic   x0, bv0, busy0, done0;
    logic   x1, bv1, busy1, done1;
    state_e st0, st1;

    serial_bit_source #(.WIDTH(W), .DIV(DIV0), .MSB_FIRST(MSB0), .IDLE_BIT(1'b1)) u0 (
        .CLOCK(clk), .reset(rst_n), .ld(if0),
        .X(x0), .bit_valid(bv0), .busy(busy0), .done(done0), .dbg_state(st0)
    );

    serial_bit_source #(.WIDTH(W), .DIV(DIV1), .MSB_FIRST(MSB1), .IDLE_BIT(1'b1)) u1 (
        .CLOCK(clk), .reset(rst_n), .ld(if1),
        .X(x1), .bit_valid(bv1), .busy(busy1), .done(done1), .dbg_state(st1)
    );

    // ---------------- check bookkeeping ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- behavioural model ----------------
    // Timeline view: which word is on the line, which bit index of it,
    // how many cycles that bit still has to stay, and the queued word.
    typedef struct {
        logic         active;
        logic         hold_full;
        logic         x;
        logic         bv;
        logic         done;
        logic [W-1:0] word;
        logic [W-1:0] hold_word;
        int           idx;
        int           left;
    } model_t;

    model_t m0, m1;
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    function automatic logic bit_of(input logic [W-1:0] w, input int idx, input bit msb);
        return msb ? w[W-1-idx] : w[idx];
    endfunction

    function automatic model_t m_reset();
        model_t m;
        m.active = 1'b0; m.hold_full = 1'b0; m.x = 1'b1; m.bv = 1'b0; m.done = 1'b0;
        m.word = '0; m.hold_word = '0; m.idx = 0; m.left = 0;
        return m;
    endfunction

    function automatic model_t start_word(input model_t m, input logic [W-1:0] w,
                                          input int div, input bit msb);
        model_t n;
        n = m;
        n.active = 1'b1; n.word = w; n.idx = 0; n.left = div;
        n.x = bit_of(w, 0, msb); n.bv = 1'b1;
        return n;
    endfunction

    function automatic model_t m_step(input model_t m, input logic acc, input logic [W-1:0] w,
                                      input int div, input bit msb);
        model_t n;
        logic   last_cycle;
        n = m;
        n.bv = 1'b0;
        n.done = 1'b0;
        last_cycle = m.active && (m.left == 1) && (m.idx == W - 1);
        if (!m.active) begin
            if (acc) n = start_word(n, w, div, msb);
        end else if (m.left > 1) begin
            n.left = m.left - 1;
        end else if (m.idx < W - 1) begin
            n.idx  = m.idx + 1;
            n.left = div;
            n.x    = bit_of(m.word, m.idx + 1, msb);
            n.bv   = 1'b1;
        end else if (m.hold_full) begin
            n = start_word(n, m.hold_word, div, msb);
            n.hold_full = 1'b0;
        end else if (acc) begin
            n = start_word(n, w, div, msb);
        end else begin
            n.active = 1'b0;
            n.x      = 1'b1;
            n.done   = 1'b1;
        end
        if (m.active && !last_cycle && acc) begin
            n.hold_full = 1'b1;
            n.hold_word = w;
        end
        return n;
    endfunction

    // Model advance on every edge; reset clears it immediately.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m0 = m_reset();
                m1 = m_reset();
                exp_q0.delete();
                exp_q1.delete();
            end else begin
                if (if0.load_valid && !m0.hold_full) exp_q0.push_back(if0.data_in);
                if (if1.load_valid && !m1.hold_full) exp_q1.push_back(if1.data_in);
                m0 = m_step(m0, if0.load_valid && !m0.hold_full, if0.data_in, DIV0, MSB0);
                m1 = m_step(m1, if1.load_valid && !m1.hold_full, if1.data_in, DIV1, MSB1);
            end
        end
    end

    // ---------------- compare process + word scoreboard ----------------
    logic [W-1:0] sr0, sr1;
    int           nb0 = 0;
    int           nb1 = 0;

    initial begin
        forever begin
            @(negedge clk);
            chk("u0.X",     x0,             m0.x);
            chk("u0.bv",    bv0,            m0.bv);
            chk("u0.busy",  busy0,          m0.active);
            chk("u0.done",  done0,          m0.done);
            chk("u0.ready", if0.load_ready, !m0.hold_full);
            chk("u1.X",     x1,             m1.x);
            chk("u1.bv",    bv1,            m1.bv);
            chk("u1.busy",  busy1,          m1.active);
            chk("u1.done",  done1,          m1.done);
            chk("u1.ready", if1.load_ready, !m1.hold_full);
            if (!rst_n) begin
                nb0 = 0;
                nb1 = 0;
            end else begin
                if (bv0) begin
                    sr0 = {sr0[W-2:0], x0};
                    nb0++;
                    if (nb0 == W) begin
                        nb0 = 0;
                        if (exp_q0.size() == 0) begin
                            n_total++;
                            $display("FAIL u0.word: got %0h with no word expected", sr0);
                        end else begin
                            chk("u0.word", sr0, exp_q0.pop_front());
                        end
                    end
                end
                if (bv1) begin
                    sr1 = {x1, sr1[W-1:1]};
                    nb1++;
                    if (nb1 == W) begin
                        nb1 = 0;
                        if (exp_q1.size() == 0) begin
                            n_total++;
                            $display("FAIL u1.word: got %0h with no word expected", sr1);
                        end else begin
                            chk("u1.word", sr1, exp_q1.pop_front());
                        end
                    end
                end
            end
        end
    end

    // ---------------- capture helpers for directed cases ----------------
    logic [63:0] cap_x, cap_bv;
    int          cap_done, cap_busy;

    task automatic cap_clear();
        cap_x = '0; cap_bv = '0; cap_done = 0; cap_busy = 0;
    endtask

    task automatic cap(input int u);
        if (u == 0) begin
            cap_x = {cap_x[62:0], x0}; cap_bv = {cap_bv[62:0], bv0};
            cap_done += int'(done0);   cap_busy += int'(busy0);
        end else begin
            cap_x = {cap_x[62:0], x1}; cap_bv = {cap_bv[62:0], bv1};
            cap_done += int'(done1);   cap_busy += int'(busy1);
        end
    endtask

    // ---------------- driver / directed sequence ----------------
    initial begin
        if0.load_valid = 1'b0; if0.data_in = '0;
        if1.load_valid = 1'b0; if1.data_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.X",     x0, 1'b1);
        chk("rst.bv",    bv0, 1'b0);
        chk("rst.busy",  busy0, 1'b0);
        chk("rst.done",  done0, 1'b0);
        chk("rst.ready", if0.load_ready, 1'b1);

        // Single word 0110_0110, MSB first, one bit per clock.
        cap_clear();
        if0.load_valid = 1'b1; if0.data_in = 8'h66;
        @(negedge clk);
        if0.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cap(0);
            @(negedge clk);
        end
        chk("single.bits", cap_x[7:0], 8'h66);
        chk("single.bv",   cap_bv[7:0], 8'hFF);
        chk("single.done", done0, 1'b1);
        chk("single.idle", x0, 1'b1);
        repeat (2) @(negedge clk);

        // Back-to-back A5 then 3C through the hold buffer.
        cap_clear();
        if0.load_valid = 1'b1; if0.data_in = 8'hA5;
        @(negedge clk);
        if0.data_in = 8'h3C;
        cap(0);
        @(negedge clk);
        if0.load_valid = 1'b0;
        for (int i = 1; i < 18; i++) begin
            cap(0);
            if (i == 7) chk("b2b.ready_held", if0.load_ready, 1'b0);
            if (i == 8) chk("b2b.ready_free", if0.load_ready, 1'b1);
            @(negedge clk);
        end
        chk("b2b.bits", cap_x[17:0], {16'hA53C, 2'b11});
        chk("b2b.bv",   cap_bv[17:0], {16'hFFFF, 2'b00});
        chk("b2b.done", cap_done, 1);
        repeat (2) @(negedge clk);

        // DIV=3, LSB first, word 01.
        cap_clear();
        if1.load_valid = 1'b1; if1.data_in = 8'h01;
        @(negedge clk);
        if1.load_valid = 1'b0;
        for (int i = 0; i < 24; i++) begin
            cap(1);
            @(negedge clk);
        end
        chk("div3.bits", cap_x[23:0], 24'hE00000);
        chk("div3.bv",   cap_bv[23:0], 24'h924924);
        chk("div3.busy", cap_busy, 24);
        chk("div3.done", done1, 1'b1);
        repeat (2) @(negedge clk);

        // Third word offered while the hold buffer is full is ignored.
        cap_clear();
        if0.load_valid = 1'b1; if0.data_in = 8'hC3;
        @(negedge clk);
        if0.data_in = 8'h5A;
        cap(0);
        @(negedge clk);
        if0.data_in = 8'hFF;
        cap(0);
        for (int i = 2; i < 20; i++) begin
            @(negedge clk);
            if (i == 3) chk("full.ready", if0.load_ready, 1'b0);
            if (i == 6) if0.load_valid = 1'b0;
            cap(0);
        end
        chk("full.bits", cap_x[19:0], {16'hC35A, 4'hF});
        chk("full.done", cap_done, 1);
        chk("full.busy", cap_busy, 16);
        repeat (2) @(negedge clk);

        // Reset in the middle of FF with 0F held.
        if0.load_valid = 1'b1; if0.data_in = 8'hFF;
        @(negedge clk);
        if0.data_in = 8'h0F;
        @(negedge clk);
        if0.load_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid.busy_before", busy0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.X",     x0, 1'b1);
        chk("mid.bv",    bv0, 1'b0);
        chk("mid.busy",  busy0, 1'b0);
        chk("mid.done",  done0, 1'b0);
        chk("mid.ready", if0.load_ready, 1'b1);
        chk("mid.state", st0, ST_IDLE);
        @(negedge clk);
        chk("mid.no_done", done0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        cap_clear();
        if0.load_valid = 1'b1; if0.data_in = 8'h81;
        @(negedge clk);
        if0.load_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            cap(0);
            @(negedge clk);
        end
        chk("after.bits", cap_x[8:0], {8'h81, 1'b1});
        chk("after.done", cap_done, 1);

        // Randomised traffic on both instances against the model.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if0.load_valid = ($urandom_range(0, 3) != 0);
            if0.data_in    = W'($urandom);
            if1.load_valid = ($urandom_range(0, 4) == 0);
            if1.data_in    = W'($urandom);
        end
        @(negedge clk);
        if0.load_valid = 1'b0;
        if1.load_valid = 1'b0;
        repeat (70) @(negedge clk);
        chk("end.q0_empty", exp_q0.size(), 0);
        chk("end.q1_empty", exp_q1.size(), 0);
        chk("end.nb0", nb0, 0);
        chk("end.nb1", nb1, 0);
        chk("end.busy0", busy0, 1'b0);
        chk("end.state1", st1, ST_IDLE);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/serial_bit_source.md
Name: serial_bit_source

Overview:
- Upstream stimulus stage for the serial sequence detectors: accepts parallel words over a valid/ready handshake and shifts them out one bit per bit-period on a single serial line X.
- X drives the detector's X input directly; bit_valid marks the first cycle of each new bit.
- A one-word holding buffer allows back-to-back words to stream with no idle gap.

Parameters:
- WIDTH, 8, bits per word (>=2)
- DIV, 1, clock cycles per serial bit (>=1); DIV=1 gives one bit per CLOCK, matching the detector
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first
- IDLE_BIT, 1, level driven on X when nothing is being sent

Ports:
- CLOCK  input  1  single clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low; 0 forces the reset state immediately
- data_in  input  WIDTH  word to send, sampled on an accepted load
- load_valid  input  1  producer has a word on data_in
- load_ready  output  1  block can take a word this cycle
- X  output  1  registered serial bit stream to the detector
- bit_valid  output  1  registered, 1 for the first cycle of each transmitted bit
- busy  output  1  1 while a word is being shifted (state SHIFT)
- done  output  1  registered one-cycle pulse when the final word finishes and the line returns to idle

Behaviour:
- Reset (reset=0): state IDLE, X=IDLE_BIT, bit_valid=0, busy=0, done=0, hold buffer empty, all counters 0. load_ready=1 once reset is released.
- load_ready = ~hold_full (decoded from a register, no combinational path from load_valid). Accept = load_valid & load_ready at a rising edge. load_valid while load_ready=0 is ignored; the word is neither stored nor counted.
- State IDLE: on accept, load the shift register. On the same edge: X <= first bit, bit_valid <= 1, div_cnt <= 0, bit_cnt <= 0, go to SHIFT. Latency is one edge from accept to the first bit on X.
- State SHIFT:
  - div_cnt counts 0..DIV-1. Each bit is held on X for exactly DIV cycles; bit_valid=1 only in the first of those cycles.
  - At div_cnt==DIV-1 with bit_cnt<WIDTH-1: X <= next bit, bit_cnt+1, bit_valid <= 1.
  - At div_cnt==DIV-1 with bit_cnt==WIDTH-1 (end of word):
    - Hold buffer full: move the hold word into the shift register, X <= its first bit, bit_valid <= 1, hold becomes empty, stay in SHIFT. No gap between words.
    - Hold buffer empty but accept on this same edge: the new word goes straight into the shift register, same as above, gapless.
    - Otherwise: X <= IDLE_BIT, done <= 1 for one cycle, go to IDLE.
  - Accept in SHIFT at any other time writes the hold buffer (hold_full <= 1).
- Bit order is set by MSB_FIRST. Counters are sized clog2(WIDTH) and clog2(DIV), minimum 1 bit each, and never wrap past their terminal values.
- Asserting reset mid-word aborts at once: the partial word and the hold word are discarded, and all outputs return to their reset values. No done pulse is produced.
- Stream throughput: one word per WIDTH*DIV cycles when load_valid stays high.

Decomposition:
- Shared package/header: state encodings (ST_IDLE=0, ST_SHIFT=1) and a clog2 constant function, reused by the detectors and benches.
- One natural sub-module: bit_tick_gen, the DIV prescaler. It produces a terminal tick, is restarted on load, and uses the same CLOCK and asynchronous active-low reset.

Test Plan:
- Reset values: hold reset=0 for 3 cycles, then release -> X=1, bit_valid=0, busy=0, done=0, load_ready=1; assert reset=0 asynchronously mid-cycle -> outputs return to reset values before the next edge.
- Single word, WIDTH=8, DIV=1, MSB_FIRST=1: data_in=8'b0110_0110 accepted at edge k -> X on edges k..k+7 = 0,1,1,0,0,1,1,0; bit_valid=1 every cycle; done=1 at edge k+8 with X=1. Chained into the detector, Z pulses twice.
- Back-to-back: load 8'hA5, then 8'h3C while busy -> 16 contiguous bits 10100101_00111100 with no idle cycle; load_ready=0 from the second accept until the hold is drained at the word boundary; exactly one done pulse.
- DIV=3, MSB_FIRST=0, data_in=8'h01 -> X=1 for 3 cycles, then 0 for 21 cycles; bit_valid high on cycles 0,3,6,...,21 of the word; busy high 24 cycles.
- Full buffer: third load_valid while shifting with hold full -> ignored; only 2 words appear on X.
- Reset mid-operation: reset=0 at bit 4 of 8'hFF with a word held -> X=IDLE_BIT, hold empty, no done pulse; the next load after release transmits correctly.
